cpu_bus_arbiter: RTL

- Sits directly downstream of the CPU core.
- Merges the core's instruction bus (read-only) and data bus (read/write) onto a single system bus master port.
- Round-robin arbitration between the two.
- Registered request/response paths, a per-transaction timeout, and debug counters.

---
 rtl/cpu_bus_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// ----------------
// Merges the CPU core's instruction bus (read-only) and data bus (read/write)
// onto one system bus master port. Round-robin between the two masters, fully
// registered request/response paths, a per-transaction timeout and two
// saturating wait counters for debug.
//
// Ports
//   i_clock, i_reset                  clock, asynchronous active-high reset
//   i_ibus_request / o_ibus_ready     instruction master handshake
//   i_ibus_address / o_ibus_rdata     fetch address / fetch data
//   i_dbus_request / o_dbus_ready     data master handshake
//   i_dbus_rw, i_dbus_address,
//   i_dbus_wdata / o_dbus_rdata       data master direction, address, data
//   o_bus_request / i_bus_ready       system bus handshake
//   o_bus_rw, o_bus_address,
//   o_bus_wdata / i_bus_rdata         system bus direction, address, data
//   o_timeout                         sticky flag, set when a transaction aborts
//   o_ibus_wait, o_dbus_wait          cycles each master spent blocked
`timescale 1ns/1ps

module cpu_bus_arbiter #(
    parameter int unsigned  TIMEOUT       = 1024,
    parameter logic [31:0]  TIMEOUT_RDATA = 32'hDEADBEEF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic        o_timeout,
    output logic [31:0] o_ibus_wait,
    output logic [31:0] o_dbus_wait
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ACK} state_t;

    localparam logic GNT_IBUS = 1'b0;
    localparam logic GNT_DBUS = 1'b1;

    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    // Abort happens at the end of the TIMEOUT-th GRANT cycle, when the
    // counter still holds TIMEOUT-1.
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d;
    // Doubles as the owner of the transaction in flight during GRANT/ACK.
    logic        last_grant_q, last_grant_d;
    logic        bus_request_q, bus_request_d;
    logic        bus_rw_q, bus_rw_d;
    logic [31:0] bus_address_q, bus_address_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        ibus_ready_q, ibus_ready_d;
    logic        dbus_ready_q, dbus_ready_d;
    logic [31:0] ibus_rdata_q, ibus_rdata_d;
    logic [31:0] dbus_rdata_q, dbus_rdata_d;
    logic        timeout_q, timeout_d;
    logic [31:0] tcount_q, tcount_d;
    logic [31:0] ibus_wait_q, ibus_wait_d;
    logic [31:0] dbus_wait_q, dbus_wait_d;

    logic        pick_dbus;
    logic        complete;
    logic [31:0] complete_rdata;
    logic        ibus_blocked;
    logic        dbus_blocked;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        bus_request_d  = bus_request_q;
        bus_rw_d       = bus_rw_q;
        bus_address_d  = bus_address_q;
        bus_wdata_d    = bus_wdata_q;
        ibus_ready_d   = 1'b0;
        dbus_ready_d   = 1'b0;
        ibus_rdata_d   = ibus_rdata_q;
        dbus_rdata_d   = dbus_rdata_q;
        timeout_d      = timeout_q;
        tcount_d       = tcount_q;
        pick_dbus      = 1'b0;
        complete       = 1'b0;
        complete_rdata = i_bus_rdata;
        ibus_blocked   = 1'b0;
        dbus_blocked   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ibus_request || i_dbus_request) begin
                    // On a tie the master that did not win last time goes next.
                    pick_dbus     = i_dbus_request &&
                                    (!i_ibus_request || (last_grant_q == GNT_IBUS));
                    last_grant_d  = pick_dbus ? GNT_DBUS : GNT_IBUS;
                    state_d       = ST_GRANT;
                    bus_request_d = 1'b1;
                    tcount_d      = 32'd0;
                    if (pick_dbus) begin
                        bus_rw_d      = i_dbus_rw;
                        bus_address_d = i_dbus_address;
                        bus_wdata_d   = i_dbus_wdata;
                        ibus_blocked  = i_ibus_request;
                    end else begin
                        bus_rw_d      = 1'b0;
                        bus_address_d = i_ibus_address;
                        bus_wdata_d   = 32'd0;
                        dbus_blocked  = i_dbus_request;
                    end
                end
            end
            ST_GRANT: begin
                tcount_d = tcount_q + 32'd1;
                // A ready on the expiry cycle wins over the timeout.
                if (i_bus_ready) begin
                    complete = 1'b1;
                end else if (TIMEOUT_EN && (tcount_q == TIMEOUT_LAST)) begin
                    complete       = 1'b1;
                    complete_rdata = TIMEOUT_RDATA;
                    timeout_d      = 1'b1;
                end
                if (complete) begin
                    bus_request_d = 1'b0;
                    state_d       = ST_ACK;
                    if (last_grant_q == GNT_DBUS) begin
                        dbus_ready_d = 1'b1;
                        dbus_rdata_d = complete_rdata;
                    end else begin
                        ibus_ready_d = 1'b1;
                        ibus_rdata_d = complete_rdata;
                    end
                end
                ibus_blocked = i_ibus_request && (last_grant_q == GNT_DBUS);
                dbus_blocked = i_dbus_request && (last_grant_q == GNT_IBUS);
            end
            ST_ACK: begin
                tcount_d     = 32'd0;
                state_d      = ST_IDLE;
                ibus_blocked = i_ibus_request && (last_grant_q == GNT_DBUS);
                dbus_blocked = i_dbus_request && (last_grant_q == GNT_IBUS);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ibus_wait_d = ibus_wait_q;
        dbus_wait_d = dbus_wait_q;
        if (ibus_blocked && (ibus_wait_q != 32'hFFFF_FFFF)) begin
            ibus_wait_d = ibus_wait_q + 32'd1;
        end
        if (dbus_blocked && (dbus_wait_q != 32'hFFFF_FFFF)) begin
            dbus_wait_d = dbus_wait_q + 32'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_IBUS;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= 32'd0;
            bus_wdata_q   <= 32'd0;
            ibus_ready_q  <= 1'b0;
            dbus_ready_q  <= 1'b0;
            ibus_rdata_q  <= 32'd0;
            dbus_rdata_q  <= 32'd0;
            timeout_q     <= 1'b0;
            tcount_q      <= 32'd0;
            ibus_wait_q   <= 32'd0;
            dbus_wait_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            bus_request_q <= bus_request_d;
            bus_rw_q      <= bus_rw_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            ibus_ready_q  <= ibus_ready_d;
            dbus_ready_q  <= dbus_ready_d;
            ibus_rdata_q  <= ibus_rdata_d;
            dbus_rdata_q  <= dbus_rdata_d;
            timeout_q     <= timeout_d;
            tcount_q      <= tcount_d;
            ibus_wait_q   <= ibus_wait_d;
            dbus_wait_q   <= dbus_wait_d;
        end
    end

    assign o_ibus_ready  = ibus_ready_q;
    assign o_ibus_rdata  = ibus_rdata_q;
    assign o_dbus_ready  = dbus_ready_q;
    assign o_dbus_rdata  = dbus_rdata_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_request = bus_request_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_timeout     = timeout_q;
    assign o_ibus_wait   = ibus_wait_q;
    assign o_dbus_wait   = dbus_wait_q;

endmodule
